// File: rtl/napot_encoder.sv
// Purpose : encode a NAPOT PMP region (byte base, log2 size k) into pmpaddr format.
// Latency : 2 cycles from accept for illegal requests or k=3, 2+(k-3) cycles otherwise.
// Backpressure: result held in DONE until rsp_ready; no new request accepted until back in IDLE.
//
// Ports:
//   clk, rst (async active-high), flush (synchronous abort)
//   req_valid/req_ready, req_base[31:0], req_size_log2[5:0]  - request handshake
//   rsp_valid/rsp_ready, rsp_pmpaddr[31:0], rsp_err          - response handshake
//   busy                                                     - state is not IDLE
module napot_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_base,
    input  logic [5:0]  req_size_log2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_pmpaddr,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_BUILD = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] base_q,  base_d;
    logic [5:0]  k_q,     k_d;
    logic [4:0]  ones_q,  ones_d;
    logic [31:0] mask_q,  mask_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] pmp_q,   pmp_d;
    logic        err_q,   err_d;

    // Alignment mask in 33 bits so that k=32 covers every address bit.
    logic [32:0] align_mask;
    logic        misaligned;
    logic        chk_err;
    logic [31:0] base_shr;
    logic [31:0] mask_next;

    assign align_mask = (33'd1 << k_q) - 33'd1;
    assign misaligned = |({1'b0, base_q} & align_mask);
    assign chk_err    = (k_q < 6'd3) || (k_q > 6'd32) || misaligned;
    assign base_shr   = base_q >> 2;
    assign mask_next  = (mask_q << 1) | 32'd1;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        ones_d  = ones_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        pmp_d   = pmp_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                // Flush wins over acceptance.
                if (!flush && req_valid) begin
                    base_d  = req_base;
                    k_d     = req_size_log2;
                    // 5-bit wrap gives 29 for k=32; out-of-range k is rejected in CHECK.
                    ones_d  = req_size_log2[4:0] - 5'd3;
                    mask_d  = 32'd0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (chk_err) begin
                    pmp_d   = 32'd0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (ones_q == 5'd0) begin
                    pmp_d   = base_shr;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = ones_q;
                    state_d = ST_BUILD;
                end
            end
            ST_BUILD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    mask_d = mask_next;
                    cnt_d  = cnt_q - 5'd1;
                    // Last step: mask_next already holds ones trailing ones.
                    if (cnt_q == 5'd1) begin
                        pmp_d   = base_shr | mask_next;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                if (flush || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= 32'd0;
            k_q     <= 6'd0;
            ones_q  <= 5'd0;
            mask_q  <= 32'd0;
            cnt_q   <= 5'd0;
            pmp_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            ones_q  <= ones_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            pmp_q   <= pmp_d;
            err_q   <= err_d;
        end
    end

    // Handshake/status outputs depend on the state register only.
    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_pmpaddr = pmp_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_napot_encoder.sv
// Purpose : self-checking bench for napot_encoder against a behavioural NAPOT model.
// Latency : measured in cycles from the accepting edge to rsp_valid.
// Backpressure: exercised with held rsp_ready and a competing request in DONE.
module tb_napot_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [5:0]  req_size_log2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pmpaddr;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    napot_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_base      (req_base),
        .req_size_log2 (req_size_log2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_pmpaddr   (rsp_pmpaddr),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference: region of 2^k bytes at base; pmpaddr = base/4 + (2^(k-3) - 1).
    function automatic void model(input logic [31:0] b, input int k,
                                  output logic [31:0] pm, output logic e, output int lat);
        logic [63:0] sz;
        logic [63:0] ones;
        e = (k < 3) || (k > 32);
        if (!e) begin
            sz = 64'd1 << k;
            if (({32'd0, b} % sz) != 64'd0) e = 1'b1;
        end
        if (e) begin
            pm  = 32'd0;
            lat = 2;
        end else begin
            ones = (64'd1 << (k - 3)) - 64'd1;
            pm   = (b / 32'd4) + ones[31:0];
            lat  = 2 + (k - 3);
        end
    endfunction

    // NAPOT matcher: region size 8 << trailing_ones(pmpaddr).
    function automatic bit napot_hit(input logic [31:0] pm, input logic [31:0] addr);
        int t;
        logic [63:0] size;
        logic [63:0] rbase;
        t = 0;
        while (t < 32 && pm[t]) t++;
        size  = 64'd8 << t;
        rbase = ({32'd0, pm} >> t << t) * 64'd4;
        return ({32'd0, addr} >= rbase) && ({32'd0, addr} < rbase + size);
    endfunction

    // Drives one request and collects the response; holds rsp_ready low for 'hold'
    // cycles in DONE and reports whether the response stayed put meanwhile.
    task automatic run_req(input logic [31:0] b, input int k, input int hold,
                           output logic [31:0] pm, output logic e, output int lat,
                           output bit timed_out, output bit stable);
        req_valid     = 1'b1;
        req_base      = b;
        req_size_log2 = 6'(k);
        rsp_ready     = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !rsp_valid;
        pm = rsp_pmpaddr;
        e  = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_pmpaddr !== pm || rsp_err !== e) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_base = 32'd0; req_size_log2 = 6'd0;
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_pmpaddr !== 32'h0) begin errors++; $display("FAIL reset_pmpaddr got=%h exp=0", rsp_pmpaddr); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] tb_b [7] = '{32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0000_1004,
                                  32'h0, 32'h0, 32'h0000_0100};
        int          tb_k [7] = '{3, 12, 32, 12, 2, 33, 32};
        logic [31:0] ex_pm[7] = '{32'h2000_0000, 32'h2000_01FF, 32'h1FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        ex_e [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int          ex_l [7] = '{2, 11, 31, 2, 2, 2, 2};
        logic [31:0] pm; logic e; int lat; bit to; bit st;
        for (int i = 0; i < 7; i++) begin
            run_req(tb_b[i], tb_k[i], 0, pm, e, lat, to, st);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout no rsp_valid", i); end
            checks++; if (pm !== ex_pm[i]) begin errors++; $display("FAIL dir%0d_pmpaddr got=%h exp=%h", i, pm, ex_pm[i]); end
            checks++; if (e !== ex_e[i]) begin errors++; $display("FAIL dir%0d_err got=%b exp=%b", i, e, ex_e[i]); end
            checks++; if (lat != ex_l[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ex_l[i]); end
        end
    endtask

    task automatic test_napot_match();
        logic [31:0] pm; logic e; int lat; bit to; bit st;
        run_req(32'h8000_0000, 12, 0, pm, e, lat, to, st);
        checks++; if (napot_hit(pm, 32'h8000_0000) !== 1'b1) begin errors++; $display("FAIL match_lo pm=%h got=miss exp=hit", pm); end
        checks++; if (napot_hit(pm, 32'h8000_0FFF) !== 1'b1) begin errors++; $display("FAIL match_hi pm=%h got=miss exp=hit", pm); end
        checks++; if (napot_hit(pm, 32'h8000_1000) !== 1'b0) begin errors++; $display("FAIL match_out pm=%h got=hit exp=miss", pm); end
    endtask

    task automatic test_random();
        logic [31:0] b, pm, ex_pm; logic e, ex_e; int k, lat, ex_lat, hold; bit to, st;
        logic [63:0] m;
        for (int i = 0; i < 40; i++) begin
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(3, 32));
            b = $urandom;
            if (k <= 32 && $urandom_range(0, 3) != 0) begin
                m = (64'd1 << k) - 64'd1;
                b = b & ~m[31:0];
            end
            hold = $urandom_range(0, 3);
            model(b, k, ex_pm, ex_e, ex_lat);
            run_req(b, k, hold, pm, e, lat, to, st);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout k=%0d", i, k); end
            checks++; if (pm !== ex_pm || e !== ex_e) begin errors++;
                $display("FAIL rnd%0d_result b=%h k=%0d got=%h/%b exp=%h/%b", i, b, k, pm, e, ex_pm, ex_e); end
            checks++; if (lat != ex_lat) begin errors++; $display("FAIL rnd%0d_latency k=%0d got=%0d exp=%0d", i, k, lat, ex_lat); end
            checks++; if (!st) begin errors++; $display("FAIL rnd%0d_hold output changed while rsp_ready=0", i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa, pb; logic ea, eb; int la, lb, n;
        model(32'h0000_1000, 5, pa, ea, la);
        model(32'h0000_0040, 3, pb, eb, lb);
        req_valid = 1'b1; req_base = 32'h0000_1000; req_size_log2 = 6'd5; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
        checks++; if (!rsp_valid) begin errors++; $display("FAIL bp_first_timeout no rsp_valid"); end
        req_valid = 1'b1; req_base = 32'h0000_0040; req_size_log2 = 6'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_pmpaddr !== pa || rsp_err !== ea) begin
                errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b pm=%h exp v=1 rdy=0 pm=%h", i, rsp_valid, req_ready, rsp_pmpaddr, pa); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle_cycle got v=%b rdy=%b busy=%b exp 0/1/0", rsp_valid, req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept got busy=%b exp=1", busy); end
        n = 1;
        while (!rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
        checks++; if (rsp_pmpaddr !== pb || rsp_err !== eb || n != lb) begin errors++;
            $display("FAIL bp_second_rsp got pm=%h lat=%0d exp pm=%h lat=%0d", rsp_pmpaddr, n, pb, lb); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        req_valid = 1'b1; req_base = 32'h0010_0000; req_size_log2 = 6'd20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL flush_pre got busy=%b v=%b exp busy=1 v=0", busy, rsp_valid); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL flush_idle got busy=%b rdy=%b v=%b exp 0/1/0", busy, req_ready, rsp_valid); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_rsp got %0d valid cycles exp 0", seen); end
        // Flush in IDLE blocks acceptance.
        req_valid = 1'b1; flush = 1'b1; req_size_log2 = 6'd3; req_base = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept got busy=%b exp=0", busy); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] pm; logic e; int lat; bit to; bit st;
        req_valid = 1'b1; req_base = 32'h0010_0000; req_size_log2 = 6'd20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_ctrl got busy=%b rdy=%b v=%b exp 0/1/0", busy, req_ready, rsp_valid); end
        checks++; if (rsp_pmpaddr !== 32'h0 || rsp_err !== 1'b0) begin errors++;
            $display("FAIL rst_mid_data got pm=%h err=%b exp 0/0", rsp_pmpaddr, rsp_err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_req(32'h4000_0000, 4, 0, pm, e, lat, to, st);
        checks++; if (to || pm !== 32'h1000_0001 || e !== 1'b0 || lat != 3) begin errors++;
            $display("FAIL rst_recover got pm=%h err=%b lat=%0d exp pm=10000001 err=0 lat=3", pm, e, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_napot_match();
        test_random();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
